// File: rtl/ex_alu_unit.sv
// ============================================================================
// Module   : ex_alu_unit
// Purpose  : Execute-stage ALU with single-cycle ops and an iterative
//            mult/div engine writing HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  localparam logic [4:0] c_add  = 5'h00, c_addu = 5'h01, c_sub  = 5'h02, c_subu = 5'h03;
  localparam logic [4:0] c_and  = 5'h04, c_or   = 5'h05, c_xor  = 5'h06, c_nor  = 5'h07;
  localparam logic [4:0] c_addi = 5'h08, c_addiu = 5'h09, c_slt = 5'h0A, c_sltu = 5'h0B;
  localparam logic [4:0] c_andi = 5'h0C, c_ori  = 5'h0D, c_xori = 5'h0E, c_lui  = 5'h0F;
  localparam logic [4:0] c_mfhi = 5'h10, c_mflo = 5'h12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic                 r_out_valid, r_overflow, r_zero;
  logic [WIDTH-1:0]     r_result, r_hi, r_lo;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand, r_src_a;
  logic                 r_is_div, r_neg_q, r_neg_r, r_b_zero;
  logic [c_cnt_w-1:0]   r_cnt;

  logic                 w_accept, w_is_md, w_signed;
  logic [WIDTH-1:0]     w_sum, w_diff, w_res, w_a_mag, w_b_mag;
  logic                 w_ovf;
  logic [WIDTH:0]       w_mul_sum, w_shift, w_trial;
  logic [2*WIDTH-1:0]   w_mul_nxt, w_div_nxt, w_prod;
  logic [WIDTH-1:0]     w_quo, w_rem, w_fix_hi, w_fix_lo;

  assign busy      = (r_state != S_IDLE);
  assign in_ready  = !busy;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

  assign w_accept = in_valid && in_ready;
  assign w_is_md  = (alu_ctrl[4:2] == 3'b110);
  assign w_signed = !alu_ctrl[0];
  assign w_a_mag  = (w_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_b_mag  = (w_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  always_comb begin
    w_sum  = src_a + src_b;
    w_diff = src_a - src_b;
    w_res  = '0;
    w_ovf  = 1'b0;
    case (alu_ctrl)
      c_add, c_addi: begin
        w_res = w_sum;
        w_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      c_addu, c_addiu: w_res = w_sum;
      c_sub: begin
        w_res = w_diff;
        w_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      c_subu:         w_res = w_diff;
      c_and, c_andi:  w_res = src_a & src_b;
      c_or, c_ori:    w_res = src_a | src_b;
      c_xor, c_xori:  w_res = src_a ^ src_b;
      c_nor:          w_res = ~(src_a | src_b);
      c_slt:          w_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      c_sltu:         w_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      c_lui:          w_res = {{(WIDTH-16){1'b0}}, src_b[15:0]} << 16;
      c_mfhi:         w_res = r_hi;
      c_mflo:         w_res = r_lo;
      default:        w_res = '0;
    endcase
  end

  // One shift-add (multiply) or restoring-subtract (divide) step on {hi,lo} of r_acc.
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_trial   = w_shift - {1'b0, r_mcand};
    w_div_nxt = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                               : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    w_prod = r_neg_q ? -r_acc : r_acc;
    w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    if (!r_is_div) begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end else if (r_b_zero) begin
      w_fix_hi = r_src_a;
      w_fix_lo = '1;
    end else begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_md) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == c_last) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_src_a     <= '0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_b_zero    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_is_md) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_overflow  <= w_ovf;
            r_zero      <= (w_res == '0);
          end else if (w_accept) begin
            // Multiplier (mult) or dividend (div) seeds the low half.
            r_is_div <= alu_ctrl[1];
            r_acc    <= {{WIDTH{1'b0}}, (alu_ctrl[1] ? w_a_mag : w_b_mag)};
            r_mcand  <= alu_ctrl[1] ? w_b_mag : w_a_mag;
            r_neg_q  <= w_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            r_neg_r  <= w_signed && src_a[WIDTH-1];
            r_b_zero <= (src_b == '0);
            r_src_a  <= src_a;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_hi        <= w_fix_hi;
          r_lo        <= w_fix_lo;
          r_result    <= w_fix_lo;
          r_overflow  <= 1'b0;
          r_zero      <= (w_fix_lo == '0);
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_alu_unit.sv
// ============================================================================
// Module   : tb_ex_alu_unit
// Purpose  : Scoreboard bench for ex_alu_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_alu_unit;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [4:0]  alu_ctrl = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        in_ready, out_valid, overflow, zero, busy;
  logic [31:0] result;

  ex_alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .result(result), .overflow(overflow), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        zr;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0, errors = 0;
  int          streak = 0, max_streak = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural meaning of each code.
  task automatic model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    longint      sa, sb, t;
    logic [63:0] p, q, r;
    longint      c_max, c_min;
    c_max = 64'sh7FFF_FFFF;
    c_min = -64'sh8000_0000;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    case (c)
      5'h00, 5'h08: begin t = sa + sb; e.res = a + b; e.ovf = (t > c_max) || (t < c_min); end
      5'h02:        begin t = sa - sb; e.res = a - b; e.ovf = (t > c_max) || (t < c_min); end
      5'h01, 5'h09: e.res = a + b;
      5'h03:        e.res = a - b;
      5'h04, 5'h0C: e.res = a & b;
      5'h05, 5'h0D: e.res = a | b;
      5'h06, 5'h0E: e.res = a ^ b;
      5'h07:        e.res = ~(a | b);
      5'h0A:        e.res = (sa < sb) ? 32'd1 : 32'd0;
      5'h0B:        e.res = (a < b) ? 32'd1 : 32'd0;
      5'h0F:        e.res = {b[15:0], 16'h0000};
      5'h10:        e.res = m_hi;
      5'h12:        e.res = m_lo;
      5'h18: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; end
      5'h19: begin p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; end
      5'h1A, 5'h1B: begin
        if (b == 32'h0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (c == 5'h1A) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
        e.res = m_lo;
      end
      default: e.res = '0;
    endcase
    e.zr = (e.res == 32'h0);
  endtask

  // Called away from an edge; returns 1ns after the accepting edge.
  task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int waited);
    exp_t e;
    waited = 0;
    model(c, a, b, e);
    sbq.push_back(e);
    in_valid = 1'b1; alu_ctrl = c; src_a = a; src_b = b;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      streak++;
      if (streak > max_streak) max_streak = streak;
      chk("busy_at_out_valid", {31'b0, busy}, 32'd0);
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid result=%h required=none", result);
      end else begin
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("overflow", {31'b0, overflow}, {31'b0, e.ovf});
        chk("zero", {31'b0, zero}, {31'b0, e.zr});
      end
    end else begin
      streak = 0;
    end
  end

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_pending", sbq.size(), 0);
  endtask

  int          w;
  logic [31:0] ra, rb;
  logic [4:0]  rc;
  logic [31:0] edges [8];

  initial begin
    edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h2, 32'hFFFF_FFFE, 32'h0000_FFFF};
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_result", result, 0);
    chk("rst_overflow", {31'b0, overflow}, 0);
    chk("rst_zero", {31'b0, zero}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    issue(5'h00, 32'h7FFF_FFFF, 32'h1, w);
    chk("add_latency", {31'b0, out_valid}, 1);
    issue(5'h01, 32'h7FFF_FFFF, 32'h1, w);
    issue(5'h02, 32'd5, 32'd5, w);
    issue(5'h0A, 32'hFFFF_FFFF, 32'h1, w);
    issue(5'h0B, 32'hFFFF_FFFF, 32'h1, w);
    issue(5'h0F, 32'hDEAD_BEEF, 32'h1234, w);
    issue(5'h1F, 32'h1234_5678, 32'h9ABC_DEF0, w);

    issue(5'h18, -32'sd3, 32'd7, w);
    issue(5'h10, 32'h0, 32'h0, w);
    chk("mult_busy_cycles", w, 33);
    issue(5'h12, 32'h0, 32'h0, w);
    issue(5'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
    issue(5'h10, 32'h0, 32'h0, w);
    issue(5'h12, 32'h0, 32'h0, w);

    issue(5'h1A, -32'sd7, 32'd2, w);
    issue(5'h00, 32'd10, 32'd20, w);
    chk("add_held_during_div", w, 33);
    issue(5'h10, 32'h0, 32'h0, w);
    issue(5'h12, 32'h0, 32'h0, w);
    issue(5'h1B, 32'd7, 32'd0, w);
    issue(5'h10, 32'h0, 32'h0, w);
    issue(5'h1A, 32'h8000_0000, 32'hFFFF_FFFF, w);
    issue(5'h10, 32'h0, 32'h0, w);

    drain();
    max_streak = 0;
    issue(5'h00, 32'd1, 32'd2, w);
    issue(5'h00, 32'd3, 32'd4, w);
    issue(5'h00, 32'd5, 32'd6, w);
    @(negedge clk); #1;
    chk("back_to_back_streak", (max_streak >= 3) ? 32'd1 : 32'd0, 32'd1);

    for (int i = 0; i < 300; i++) begin
      rc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 27)) : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 7)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 7)] : $urandom;
      issue(rc, ra, rb, w);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();

    issue(5'h18, 32'h1234_5678, 32'h9ABC_DEF1, w);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 1);
    chk("async_rst_out_valid", {31'b0, out_valid}, 0);
    chk("async_rst_result", result, 0);
    sbq.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(5'h10, 32'h0, 32'h0, w);
    issue(5'h12, 32'h0, 32'h0, w);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
